// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU result path: word layout, status encodings
// and the packed entry stored by the result FIFO.
package fpu_pkg;

   localparam int DATA_W = 32;
   localparam int EXP_W  = 10;
   localparam int MAN_W  = 21;
   localparam int STAT_W = 4;

   typedef enum logic [STAT_W-1:0] {
      ST_WAIT      = 4'b0000,
      ST_EXACT     = 4'b0001,
      ST_OVERFLOW  = 4'b0010,
      ST_UNDERFLOW = 4'b0100,
      ST_INEXACT   = 4'b1000
   } status_e;

   // Event counter index matches the status bit position
   localparam int BIT_EXACT = 0;
   localparam int BIT_OVF   = 1;
   localparam int BIT_UNF   = 2;
   localparam int BIT_INX   = 3;

   typedef struct packed {
      logic [STAT_W-1:0] status;
      logic [DATA_W-1:0] data;
   } entry_t;

endpackage

// File: rtl/fpu_result_fifo.sv
// Result FIFO: unreset storage array, wrapping pointers, occupancy count and
// a registered read port with one-cycle latency.
module fpu_result_fifo
   import fpu_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clock_100KHz,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   wr_en,
   input  logic                   rd_en,
   input  entry_t                 wr_entry,
   output entry_t                 rd_entry,
   output logic                   rd_valid,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == OCC_W'(DEPTH));
   // A pop frees the head slot in the same edge, so a full FIFO still accepts
   assign do_pop  = rd_en && !empty && !clear;
   assign do_push = wr_en && (!full || do_pop) && !clear;

   always_ff @(posedge clock_100KHz) begin
      if (do_push) mem[wr_ptr] <= wr_entry;
   end

   always_ff @(posedge clock_100KHz or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rd_entry <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= do_pop;
         if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop) begin
               rd_ptr   <= rd_ptr + PTR_W'(1);
               rd_entry <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
               2'b10:   count <= count + OCC_W'(1);
               2'b01:   count <= count - OCC_W'(1);
               default: count <= count;
            endcase
         end
      end
   end

endmodule

// File: rtl/fpu_result_capture.sv
// Captures non-WAIT FPU results into a FIFO, counts status events with
// saturation and flags results lost to a full FIFO.
module fpu_result_capture
   import fpu_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CNT_W = 8
) (
   input  logic                   clock_100KHz,
   input  logic                   reset,
   input  logic                   res_valid_in,
   input  logic [DATA_W-1:0]      data_in,
   input  logic [STAT_W-1:0]      status_in,
   input  logic                   clear_in,
   input  logic                   rd_en_in,
   output logic [DATA_W-1:0]      rd_data_out,
   output logic [STAT_W-1:0]      rd_status_out,
   output logic                   rd_valid_out,
   output logic                   empty_out,
   output logic                   full_out,
   output logic [$clog2(DEPTH):0] count_out,
   output logic [CNT_W-1:0]       cnt_exact_out,
   output logic [CNT_W-1:0]       cnt_ovf_out,
   output logic [CNT_W-1:0]       cnt_unf_out,
   output logic [CNT_W-1:0]       cnt_inx_out,
   output logic                   drop_out
);

   // Handshake: res_valid_in is a one-cycle qualifier with no backpressure;
   // rd_en_in pops only when not empty, and rd_valid_out marks the popped
   // word exactly one cycle later.
   logic             capture;
   logic             pop_ok;
   logic             fifo_empty;
   logic             fifo_full;
   entry_t           wr_entry;
   entry_t           rd_entry;
   logic [CNT_W-1:0] ev_cnt [STAT_W];

   assign capture  = res_valid_in && (status_in != ST_WAIT);
   assign pop_ok   = rd_en_in && !fifo_empty;
   assign wr_entry = '{status: status_in, data: data_in};

   fpu_result_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock_100KHz (clock_100KHz),
      .reset        (reset),
      .clear        (clear_in),
      .wr_en        (capture),
      .rd_en        (rd_en_in),
      .wr_entry     (wr_entry),
      .rd_entry     (rd_entry),
      .rd_valid     (rd_valid_out),
      .empty        (fifo_empty),
      .full         (fifo_full),
      .count        (count_out)
   );

   // Counters track every captured result, including ones the FIFO drops
   always_ff @(posedge clock_100KHz or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < STAT_W; i++) ev_cnt[i] <= '0;
         drop_out <= 1'b0;
      end else if (clear_in) begin
         for (int i = 0; i < STAT_W; i++) ev_cnt[i] <= '0;
         drop_out <= 1'b0;
      end else if (capture) begin
         for (int i = 0; i < STAT_W; i++) begin
            if (status_in[i] && (ev_cnt[i] != '1)) ev_cnt[i] <= ev_cnt[i] + CNT_W'(1);
         end
         if (fifo_full && !pop_ok) drop_out <= 1'b1;
      end
   end

   assign rd_data_out   = rd_entry.data;
   assign rd_status_out = rd_entry.status;
   assign empty_out     = fifo_empty;
   assign full_out      = fifo_full;
   assign cnt_exact_out = ev_cnt[BIT_EXACT];
   assign cnt_ovf_out   = ev_cnt[BIT_OVF];
   assign cnt_unf_out   = ev_cnt[BIT_UNF];
   assign cnt_inx_out   = ev_cnt[BIT_INX];

endmodule

// File: tb/tb_fpu_result_capture.sv
// Directed bench for fpu_result_capture: queue-based reference model checked
// every cycle plus hand-computed literal expectations.
module tb_fpu_result_capture;

   localparam int DEPTH = 8;
   localparam int CNT_W = 8;
   localparam int CMAX  = 255;

   logic        clock_100KHz = 1'b0;
   logic        reset        = 1'b0;
   logic        res_valid_in = 1'b0;
   logic [31:0] data_in      = '0;
   logic [3:0]  status_in    = '0;
   logic        clear_in     = 1'b0;
   logic        rd_en_in     = 1'b0;
   logic [31:0] rd_data_out;
   logic [3:0]  rd_status_out;
   logic        rd_valid_out;
   logic        empty_out;
   logic        full_out;
   logic [3:0]  count_out;
   logic [7:0]  cnt_exact_out;
   logic [7:0]  cnt_ovf_out;
   logic [7:0]  cnt_unf_out;
   logic [7:0]  cnt_inx_out;
   logic        drop_out;

   fpu_result_capture #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clock_100KHz  (clock_100KHz),
      .reset         (reset),
      .res_valid_in  (res_valid_in),
      .data_in       (data_in),
      .status_in     (status_in),
      .clear_in      (clear_in),
      .rd_en_in      (rd_en_in),
      .rd_data_out   (rd_data_out),
      .rd_status_out (rd_status_out),
      .rd_valid_out  (rd_valid_out),
      .empty_out     (empty_out),
      .full_out      (full_out),
      .count_out     (count_out),
      .cnt_exact_out (cnt_exact_out),
      .cnt_ovf_out   (cnt_ovf_out),
      .cnt_unf_out   (cnt_unf_out),
      .cnt_inx_out   (cnt_inx_out),
      .drop_out      (drop_out)
   );

   always #5 clock_100KHz = ~clock_100KHz;

   int total = 0;
   int bad   = 0;
   bit cmp_en = 1'b0;

   task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of {status,data} plus integer counters
   logic [35:0] m_q[$];
   int          m_cnt[4];
   bit          m_drop      = 1'b0;
   bit          m_rd_valid  = 1'b0;
   logic [31:0] m_rd_data   = '0;
   logic [3:0]  m_rd_status = '0;
   bit          m_pop_ok;
   logic [35:0] m_item;

   always @(posedge clock_100KHz or negedge reset) begin
      if (!reset) begin
         m_q.delete();
         for (int i = 0; i < 4; i++) m_cnt[i] = 0;
         m_drop = 0; m_rd_valid = 0; m_rd_data = '0; m_rd_status = '0;
      end else begin
         m_rd_valid = 0;
         if (clear_in) begin
            m_q.delete();
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            m_drop = 0;
         end else begin
            m_pop_ok = rd_en_in && (m_q.size() > 0);
            if (m_pop_ok) begin
               m_item = m_q.pop_front();
               {m_rd_status, m_rd_data} = m_item;
               m_rd_valid = 1;
            end
            if (res_valid_in && status_in != 4'b0000) begin
               for (int i = 0; i < 4; i++)
                  if (status_in[i] && m_cnt[i] < CMAX) m_cnt[i]++;
               if (m_q.size() < DEPTH) m_q.push_back({status_in, data_in});
               else m_drop = 1;
            end
         end
      end
   end

   always @(negedge clock_100KHz) begin
      if (cmp_en) begin
         check("rd_valid", rd_valid_out, m_rd_valid);
         check("rd_data", rd_data_out, m_rd_data);
         check("rd_status", rd_status_out, m_rd_status);
         check("count", count_out, m_q.size());
         check("empty", empty_out, m_q.size() == 0);
         check("full", full_out, m_q.size() == DEPTH);
         check("cnt_exact", cnt_exact_out, m_cnt[0]);
         check("cnt_ovf", cnt_ovf_out, m_cnt[1]);
         check("cnt_unf", cnt_unf_out, m_cnt[2]);
         check("cnt_inx", cnt_inx_out, m_cnt[3]);
         check("drop", drop_out, m_drop);
      end
   end

   task automatic tick();
      @(posedge clock_100KHz);
      #2;
   endtask

   task automatic push(input logic [31:0] d, input logic [3:0] s);
      res_valid_in = 1; data_in = d; status_in = s;
      tick();
      res_valid_in = 0; status_in = '0;
   endtask

   task automatic do_clear();
      clear_in = 1;
      tick();
      clear_in = 0;
   endtask

   task automatic pop_expect(input string name, input logic [31:0] d, input logic [3:0] s);
      rd_en_in = 1;
      tick();
      rd_en_in = 0;
      check({name, "_valid"}, rd_valid_out, 1'b1);
      check({name, "_data"}, rd_data_out, d);
      check({name, "_status"}, rd_status_out, s);
      tick();
      check({name, "_pulse_end"}, rd_valid_out, 1'b0);
   endtask

   logic [3:0] st9 [9] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd9, 4'd3, 4'd12, 4'd15, 4'd8};

   initial begin
      tick(); tick();
      cmp_en = 1;
      check("rst_empty", empty_out, 1'b1);
      check("rst_count", count_out, 4'd0);
      check("rst_rd_data", rd_data_out, 32'h0);
      reset = 1;
      tick();

      // Three results, then pop in order
      push(32'h40200000, 4'b0001);
      push(32'h40300001, 4'b1000);
      push(32'h7FE00000, 4'b0010);
      check("three_count", count_out, 4'd3);
      check("three_exact", cnt_exact_out, 8'd1);
      check("three_inx", cnt_inx_out, 8'd1);
      check("three_ovf", cnt_ovf_out, 8'd1);
      pop_expect("pop1", 32'h40200000, 4'b0001);
      pop_expect("pop2", 32'h40300001, 4'b1000);
      pop_expect("pop3", 32'h7FE00000, 4'b0010);
      check("drained_empty", empty_out, 1'b1);

      // Empty pop and a WAIT pulse change nothing
      do_clear();
      rd_en_in = 1; res_valid_in = 1; status_in = 4'b0000; data_in = 32'hDEADBEEF;
      tick();
      rd_en_in = 0; res_valid_in = 0;
      check("idle_valid", rd_valid_out, 1'b0);
      check("idle_count", count_out, 4'd0);
      check("idle_hold_data", rd_data_out, 32'h7FE00000);
      check("idle_exact", cnt_exact_out, 8'd0);
      check("idle_inx", cnt_inx_out, 8'd0);

      // Overfill: 9 writes into 8 entries
      for (int i = 0; i < 9; i++) begin
         push(32'h10000000 + i, st9[i]);
         if (i == 7) begin
            check("fill8_full", full_out, 1'b1);
            check("fill8_drop", drop_out, 1'b0);
         end
      end
      check("over_full", full_out, 1'b1);
      check("over_drop", drop_out, 1'b1);
      check("over_count", count_out, 4'd8);
      check("over_exact", cnt_exact_out, 8'd4);
      check("over_ovf", cnt_ovf_out, 8'd3);
      check("over_unf", cnt_unf_out, 8'd3);
      check("over_inx", cnt_inx_out, 8'd5);

      // Full FIFO: write and pop in the same cycle
      do_clear();
      for (int i = 0; i < 8; i++) push(32'h20000000 + i, 4'b0001);
      res_valid_in = 1; data_in = 32'hABCD0001; status_in = 4'b1000; rd_en_in = 1;
      tick();
      res_valid_in = 0; rd_en_in = 0; status_in = '0;
      check("wp_full_count", count_out, 4'd8);
      check("wp_full_drop", drop_out, 1'b0);
      check("wp_full_data", rd_data_out, 32'h20000000);
      for (int i = 0; i < 7; i++) begin
         rd_en_in = 1; tick(); rd_en_in = 0; tick();
      end
      pop_expect("wrap_tail", 32'hABCD0001, 4'b1000);

      // Empty FIFO: write and pop in the same cycle stores the write only
      res_valid_in = 1; data_in = 32'h5555AAAA; status_in = 4'b0100; rd_en_in = 1;
      tick();
      res_valid_in = 0; rd_en_in = 0; status_in = '0;
      check("wp_empty_count", count_out, 4'd1);
      check("wp_empty_valid", rd_valid_out, 1'b0);
      pop_expect("wp_empty_pop", 32'h5555AAAA, 4'b0100);

      // Counter saturation
      do_clear();
      for (int i = 0; i < 300; i++) begin
         res_valid_in = 1; data_in = 32'h3F000000 + i; status_in = 4'b1000; rd_en_in = 1;
         tick();
      end
      res_valid_in = 0; rd_en_in = 0; status_in = '0;
      check("sat_inx", cnt_inx_out, 8'd255);
      check("sat_exact", cnt_exact_out, 8'd0);
      do_clear();
      check("clr_inx", cnt_inx_out, 8'd0);
      check("clr_empty", empty_out, 1'b1);

      // Clear wins over simultaneous write and pop
      push(32'h11111111, 4'b0001);
      push(32'h22222222, 4'b0001);
      clear_in = 1; res_valid_in = 1; status_in = 4'b0001; data_in = 32'h99999999; rd_en_in = 1;
      tick();
      clear_in = 0; res_valid_in = 0; rd_en_in = 0; status_in = '0;
      check("clrpri_count", count_out, 4'd0);
      check("clrpri_valid", rd_valid_out, 1'b0);
      check("clrpri_exact", cnt_exact_out, 8'd0);

      // Reset right after a pop request
      push(32'h33333333, 4'b0001);
      rd_en_in = 1;
      tick();
      rd_en_in = 0;
      reset = 0;
      #1;
      check("rstpop_valid", rd_valid_out, 1'b0);
      check("rstpop_data", rd_data_out, 32'h0);
      check("rstpop_status", rd_status_out, 4'h0);
      check("rstpop_count", count_out, 4'd0);
      tick(); tick();
      reset = 1;
      tick(); tick();
      check("rstpop_after_valid", rd_valid_out, 1'b0);
      check("rstpop_after_empty", empty_out, 1'b1);

      cmp_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
